fp_addsub_pipe: RTL and testbench
=================================

Name: fp_addsub_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point add/subtract unit for the FADD reservation-station path.
- Accepts one operation per cycle under a valid/ready handshake and carries a reservation-station tag through to the result.
- Rounds to nearest-even and raises status flags.
- Adds handling of special values (zero, infinity, NaN) and optional subtraction.

Parameters:
- EXP_W, 8: exponent field width.
- MAN_W, 23: stored fraction width; hidden bit is implicit. Word width W = 1+EXP_W+MAN_W.
- TAG_W, 4: reservation-station tag width, carried unchanged.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  unit can accept this cycle.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_sub  in  1  0: A+B, 1: A−B (B sign inverted at capture).
- in_tag  in  TAG_W  tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_res  out  W  rounded result.
- out_tag  out  TAG_W  tag of result.
- out_flags  out  4  {invalid, overflow, inexact, zero}.

Behaviour:
- Reset (rst_n low, async): all stage valid bits 0; out_valid=0; out_res=0; out_tag=0; out_flags=0. in_ready=1 once rst_n is high. Reset mid-operation discards all in-flight ops; no partial result ever appears.
- Pipeline has 4 register stages, so latency is exactly 4 cycles from accepted input to out_valid when unstalled. Throughput is 1 per cycle.
  - S1: unpack, sign-adjust B, magnitude compare/swap so |A'|≥|B'|, classify specials, exponent difference D.
  - S2: align smaller mantissa right by min(D, MAN_W+3), keeping guard, round and sticky bits (sticky = OR of all bits shifted out); add or subtract by effective sign.
  - S3: leading-one detect and normalise. Left-shift up to MAN_W+1 with exponent decrement, or right-shift by 1 on carry-out with exponent increment (sticky preserved).
  - S4: round to nearest-even (round up iff G & (R|S|LSB)); re-normalise on mantissa overflow; pack; flag.
- Handshake:
  - Global advance enable en = out_ready | ~out_valid.
  - in_ready = en.
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - When en=0 all stages hold, including data, valid and tag. Bubbles propagate as valid=0.
  - Simultaneous accept and deliver in one cycle is required to work at full rate.
- Arithmetic rules:
  - Denormal inputs (exp=0) are treated as signed zero; there are no denormal outputs. A result exponent ≤0 flushes to signed zero and sets the zero and inexact flags.
  - Exact cancellation gives +0, or −0 only when both effective operands are −0.
  - Result exponent ≥ all-ones gives ±infinity, with overflow=1 and inexact=1.
  - inexact=1 whenever any of G, R or S is nonzero before rounding.
- Specials (resolved in S1, bypassing arithmetic but keeping the same latency):
  - Any NaN input gives quiet NaN {0, all-ones exp, 1 followed by zeros}.
  - +inf + −inf (effective) gives quiet NaN with invalid=1.
  - inf ± finite gives that inf, no flags.
  - x ± 0 gives x exactly.
- zero flag = result magnitude is 0.
- Tag and flags travel alongside data; out_tag always matches the op that produced out_res.
- No combinational path from in_* to out_*. The only combinational path is out_ready to in_ready.

Test Plan:
- 0x3F800000 + 0x40000000, sub=0 → after 4 cycles out_res=0x40400000, flags=0000, out_tag equals the input tag.
- 0x40400000 − 0x40400000 (sub=1) → 0x00000000, flags zero=1, others 0.
- Tie to even:
  - 0x3F800000 + 0x33800000 → 0x3F800000, inexact=1.
  - 0x3F800001 + 0x33800000 → 0x3F800002, inexact=1.
- Overflow and specials:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, invalid=1.
- Stream of 10 back-to-back ops with tags 0..9; hold out_ready=0 for cycles 6–9 → in_ready low exactly while out_valid & ~out_ready; all 10 results emerge in order with no loss or duplication.
- Assert rst_n low asynchronously mid-clock with 3 ops in flight → out_valid drops immediately; after release, the first new op appears 4 cycles after acceptance and old ops never appear.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: four-stage floating-point add/subtract with round-to-nearest-even,
// special-value handling, a tag carried with each op and a single global stall.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_sub,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_res,
    output logic [TAG_W-1:0]     out_tag,
    output logic [3:0]           out_flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int MW  = MAN_W + 4;          // {hidden, fraction, G, R, S}
    localparam int EW  = EXP_W + 2;          // signed working exponent
    localparam int LZW = $clog2(MW);
    localparam logic [EXP_W-1:0]      EXP_ONES = {EXP_W{1'b1}};
    localparam logic [W-1:0]          QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW-1:0]  E_MAX    = $signed({2'b00, EXP_ONES});
    localparam logic signed [EW-1:0]  E_ONE    = EW'(1);
    localparam logic signed [EW-1:0]  E_ZERO   = EW'(0);
    localparam logic [EXP_W-1:0]      SH_MAX   = EXP_W'(MW - 1);

    // Round to nearest even; the extra top bit flags mantissa overflow.
    function automatic logic [MAN_W+1:0] round_ne(input logic [MW-1:0] m);
        logic up;
        up = m[2] & (m[1] | m[0] | m[3]);
        return {1'b0, m[MW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    endfunction

    // Saturate to infinity or flush to signed zero; returns {flags, result}.
    function automatic logic [W+3:0] saturate(input logic sgn, input logic signed [EW-1:0] e,
                                               input logic [MAN_W-1:0] f, input logic inx);
        if (e >= E_MAX)
            return {4'b0110, sgn, EXP_ONES, {MAN_W{1'b0}}};
        else if (e < E_ONE)
            return {4'b0011, sgn, {(W-1){1'b0}}};
        else
            return {2'b00, inx, 1'b0, sgn, e[EXP_W-1:0], f};
    endfunction

    // Leading-zero count over the un-carried sum.
    function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] m);
        logic [LZW-1:0] n;
        n = '0;
        for (int i = 0; i < MW; i++)
            if (m[i]) n = LZW'(MW - 1 - i);
        return n;
    endfunction

    logic en;
    logic out_valid_q;
    assign en       = out_ready | ~out_valid_q;
    assign in_ready = en;

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;

    assign sa     = in_a[W-1];
    assign sb     = in_b[W-1] ^ in_sub;
    assign ea     = in_a[W-2:MAN_W];
    assign eb     = in_b[W-2:MAN_W];
    assign fa     = in_a[MAN_W-1:0];
    assign fb     = in_b[MAN_W-1:0];
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign swap   = in_b[W-2:0] > in_a[W-2:0];

    logic             vld_p1_q, vld_p2_q, vld_p3_q;
    logic [TAG_W-1:0] tag_p1_q, tag_p2_q, tag_p3_q;

    logic             sgn_l_p1_d, sgn_s_p1_d, spec_p1_d;
    logic [EXP_W-1:0] exp_l_p1_d, dexp_p1_d;
    logic [MAN_W:0]   man_l_p1_d, man_s_p1_d;
    logic [W-1:0]     spec_res_p1_d;
    logic [3:0]       spec_flg_p1_d;

    logic             sgn_l_p1_q, sgn_s_p1_q, spec_p1_q;
    logic [EXP_W-1:0] exp_l_p1_q, dexp_p1_q;
    logic [MAN_W:0]   man_l_p1_q, man_s_p1_q;
    logic [W-1:0]     spec_res_p1_q;
    logic [3:0]       spec_flg_p1_q;

    // Stage 1: classify, order operands so |L| >= |S|, resolve specials.
    always_comb begin
        sgn_l_p1_d    = swap ? sb : sa;
        sgn_s_p1_d    = swap ? sa : sb;
        exp_l_p1_d    = swap ? eb : ea;
        dexp_p1_d     = swap ? (eb - ea) : (ea - eb);
        man_l_p1_d    = {1'b1, swap ? fb : fa};
        man_s_p1_d    = {1'b1, swap ? fa : fb};
        spec_p1_d     = 1'b1;
        spec_res_p1_d = '0;
        spec_flg_p1_d = 4'b0000;
        if (a_nan || b_nan) begin
            spec_res_p1_d = QNAN;
        end else if (a_inf && b_inf) begin
            if (sa != sb) begin
                spec_res_p1_d = QNAN;
                spec_flg_p1_d = 4'b1000;
            end else begin
                spec_res_p1_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
            end
        end else if (a_inf) begin
            spec_res_p1_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_res_p1_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            spec_res_p1_d = {sa & sb, {(W-1){1'b0}}};
            spec_flg_p1_d = 4'b0001;
        end else if (b_zero) begin
            spec_res_p1_d = in_a;
        end else if (a_zero) begin
            spec_res_p1_d = {sb, in_b[W-2:0]};
        end else begin
            spec_p1_d = 1'b0;
        end
    end

    logic [EXP_W-1:0] shamt;
    logic [2*MW-1:0]  wide;
    logic [MW-1:0]    man_al;
    logic [MW:0]      sum_p2_d;

    logic             sgn_p2_q, spec_p2_q;
    logic [EXP_W-1:0] exp_l_p2_q;
    logic [MW:0]      sum_p2_q;
    logic [W-1:0]     spec_res_p2_q;
    logic [3:0]       spec_flg_p2_q;

    // Stage 2: align the smaller mantissa collecting sticky, then add or subtract.
    always_comb begin
        shamt     = (dexp_p1_q > SH_MAX) ? SH_MAX : dexp_p1_q;
        wide      = {man_s_p1_q, 3'b000, {MW{1'b0}}} >> shamt;
        man_al    = wide[2*MW-1:MW];
        man_al[0] = man_al[0] | (|wide[MW-1:0]);
        if (sgn_l_p1_q ^ sgn_s_p1_q)
            sum_p2_d = {1'b0, man_l_p1_q, 3'b000} - {1'b0, man_al};
        else
            sum_p2_d = {1'b0, man_l_p1_q, 3'b000} + {1'b0, man_al};
    end

    logic [LZW-1:0]          lz;
    logic [MW-1:0]           man_p3_d;
    logic signed [EW-1:0]    exp_p3_d;
    logic                    zero_p3_d;

    logic                    sgn_p3_q, spec_p3_q, zero_p3_q;
    logic [MW-1:0]           man_p3_q;
    logic signed [EW-1:0]    exp_p3_q;
    logic [W-1:0]            spec_res_p3_q;
    logic [3:0]              spec_flg_p3_q;

    // Stage 3: normalise on carry-out (right by one) or by leading-zero count.
    always_comb begin
        lz        = lzc(sum_p2_q[MW-1:0]);
        zero_p3_d = (sum_p2_q == '0);
        if (sum_p2_q[MW]) begin
            man_p3_d = {sum_p2_q[MW:2], sum_p2_q[1] | sum_p2_q[0]};
            exp_p3_d = $signed({2'b00, exp_l_p2_q}) + E_ONE;
        end else begin
            man_p3_d = sum_p2_q[MW-1:0] << lz;
            exp_p3_d = $signed({2'b00, exp_l_p2_q}) - $signed({{(EW-LZW){1'b0}}, lz});
        end
    end

    logic [MAN_W+1:0]     rnd;
    logic [MAN_W-1:0]     frac4;
    logic signed [EW-1:0] exp4;
    logic                 inexact4;
    logic [W+3:0]         packed4;
    logic [W-1:0]         out_res_d;
    logic [3:0]           out_flags_d;

    logic [W-1:0]         out_res_q;
    logic [TAG_W-1:0]     out_tag_q;
    logic [3:0]           out_flags_q;

    // Stage 4: round, re-normalise, saturate/flush and pick the special result.
    always_comb begin
        rnd      = round_ne(man_p3_q);
        frac4    = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        exp4     = exp_p3_q + (rnd[MAN_W+1] ? E_ONE : E_ZERO);
        inexact4 = |man_p3_q[2:0];
        packed4  = saturate(sgn_p3_q, exp4, frac4, inexact4);
        if (spec_p3_q)
            {out_flags_d, out_res_d} = {spec_flg_p3_q, spec_res_p3_q};
        else if (zero_p3_q)
            {out_flags_d, out_res_d} = {4'b0001, {W{1'b0}}};
        else
            {out_flags_d, out_res_d} = packed4;
    end

    // Control: stage valids and the visible output register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            vld_p3_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_tag_q   <= '0;
            out_flags_q <= '0;
        end else if (en) begin
            vld_p1_q    <= in_valid;
            vld_p2_q    <= vld_p1_q;
            vld_p3_q    <= vld_p2_q;
            out_valid_q <= vld_p3_q;
            if (vld_p3_q) begin
                out_res_q   <= out_res_d;
                out_tag_q   <= tag_p3_q;
                out_flags_q <= out_flags_d;
            end
        end
    end

    // Datapath: no reset needed, every stage is qualified by its valid bit.
    always_ff @(posedge clk) begin
        if (en) begin
            tag_p1_q      <= in_tag;
            sgn_l_p1_q    <= sgn_l_p1_d;
            sgn_s_p1_q    <= sgn_s_p1_d;
            exp_l_p1_q    <= exp_l_p1_d;
            dexp_p1_q     <= dexp_p1_d;
            man_l_p1_q    <= man_l_p1_d;
            man_s_p1_q    <= man_s_p1_d;
            spec_p1_q     <= spec_p1_d;
            spec_res_p1_q <= spec_res_p1_d;
            spec_flg_p1_q <= spec_flg_p1_d;

            tag_p2_q      <= tag_p1_q;
            sgn_p2_q      <= sgn_l_p1_q;
            exp_l_p2_q    <= exp_l_p1_q;
            sum_p2_q      <= sum_p2_d;
            spec_p2_q     <= spec_p1_q;
            spec_res_p2_q <= spec_res_p1_q;
            spec_flg_p2_q <= spec_flg_p1_q;

            tag_p3_q      <= tag_p2_q;
            sgn_p3_q      <= sgn_p2_q;
            man_p3_q      <= man_p3_d;
            exp_p3_q      <= exp_p3_d;
            zero_p3_q     <= zero_p3_d;
            spec_p3_q     <= spec_p2_q;
            spec_res_p3_q <= spec_res_p2_q;
            spec_flg_p3_q <= spec_flg_p2_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_tag   = out_tag_q;
    assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe with single-precision parameters.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_res;
    logic [3:0]  out_tag;
    logic [3:0]  out_flags;

    int checks = 0;
    int errors = 0;

    // 1.0 .. 12.0 in single precision
    logic [31:0] ftab [0:11] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                                 32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag), .out_flags(out_flags)
    );

    // Drive one op, wait (bounded) for its result, capture it and let it drain.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [3:0] tag, output logic [31:0] res,
                          output logic [3:0] flg, output logic [3:0] otag, output int lat);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_res; flg = out_flags; otag = out_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_res !== 32'h0) begin errors++; $display("FAIL reset_res got %h want 00000000", out_res); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_tag got %h want 0", out_tag); end
        checks++; if (out_flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %b want 0000", out_flags); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
    endtask

    task automatic test_arith;
        logic [31:0] r; logic [3:0] f, t; int lat;
        run_op(32'h3F800000, 32'h40000000, 1'b0, 4'h5, r, f, t, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL add_latency got %0d want 4", lat); end
        checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL add_res got %h want 40400000", r); end
        checks++; if (f !== 4'b0000) begin errors++; $display("FAIL add_flags got %b want 0000", f); end
        checks++; if (t !== 4'h5) begin errors++; $display("FAIL add_tag got %h want 5", t); end
        run_op(32'h40400000, 32'h40400000, 1'b1, 4'h6, r, f, t, lat);
        checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL cancel_res got %h want 00000000", r); end
        checks++; if (f !== 4'b0001) begin errors++; $display("FAIL cancel_flags got %b want 0001", f); end
        run_op(32'h40400000, 32'h3F800000, 1'b1, 4'h7, r, f, t, lat);
        checks++; if (r !== 32'h40000000 || f !== 4'b0000) begin errors++; $display("FAIL sub_3m1 got %h/%b want 40000000/0000", r, f); end
        run_op(32'h3F800000, 32'hBFC00000, 1'b0, 4'h8, r, f, t, lat);
        checks++; if (r !== 32'hBF000000 || f !== 4'b0000) begin errors++; $display("FAIL add_neg got %h/%b want BF000000/0000", r, f); end
    endtask

    task automatic test_rounding;
        logic [31:0] va [0:3] = '{32'h3F800000, 32'h3F800001, 32'h3F800000, 32'h3F800000};
        logic [31:0] vb [0:3] = '{32'h33800000, 32'h33800000, 32'h33C00000, 32'h33000000};
        logic [31:0] vr [0:3] = '{32'h3F800000, 32'h3F800002, 32'h3F800001, 32'h3F800000};
        logic [31:0] r; logic [3:0] f, t; int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], 1'b0, 4'(i), r, f, t, lat);
            checks++; if (r !== vr[i]) begin errors++; $display("FAIL round_res[%0d] got %h want %h", i, r, vr[i]); end
            checks++; if (f !== 4'b0010) begin errors++; $display("FAIL round_flags[%0d] got %b want 0010", i, f); end
        end
    endtask

    task automatic test_range;
        logic [31:0] r; logic [3:0] f, t; int lat;
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'h9, r, f, t, lat);
        checks++; if (r !== 32'h7F800000) begin errors++; $display("FAIL ovf_res got %h want 7F800000", r); end
        checks++; if (f !== 4'b0110) begin errors++; $display("FAIL ovf_flags got %b want 0110", f); end
        run_op(32'h00800000, 32'h00800001, 1'b1, 4'hA, r, f, t, lat);
        checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL flush_res got %h want 80000000", r); end
        checks++; if (f !== 4'b0011) begin errors++; $display("FAIL flush_flags got %b want 0011", f); end
    endtask

    task automatic test_specials;
        logic [31:0] va [0:7] = '{32'h7F800000, 32'h7FC00001, 32'h3F800000, 32'h40490FDB,
                                  32'h80000000, 32'h80000000, 32'h00000000, 32'h00400000};
        logic [31:0] vb [0:7] = '{32'hFF800000, 32'h3F800000, 32'h7F800000, 32'h00000000,
                                  32'h80000000, 32'h00000000, 32'h80000000, 32'h3F800000};
        logic        vs [0:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] vr [0:7] = '{32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h40490FDB,
                                  32'h80000000, 32'h80000000, 32'h00000000, 32'h3F800000};
        logic [3:0]  vf [0:7] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000,
                                  4'b0001, 4'b0001, 4'b0001, 4'b0000};
        logic [31:0] r; logic [3:0] f, t; int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], vs[i], 4'(i + 8), r, f, t, lat);
            checks++; if (r !== vr[i]) begin errors++; $display("FAIL special_res[%0d] got %h want %h", i, r, vr[i]); end
            checks++; if (f !== vf[i]) begin errors++; $display("FAIL special_flags[%0d] got %b want %b", i, f, vf[i]); end
            checks++; if (lat != 4) begin errors++; $display("FAIL special_latency[%0d] got %0d want 4", i, lat); end
        end
    endtask

    task automatic test_back_to_back;
        int sent, rcvd;
        sent = 0; rcvd = 0;
        for (int cyc = 0; cyc < 60 && rcvd < 10; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 9);
            if (sent < 10) begin
                in_valid = 1'b1; in_a = ftab[sent]; in_b = ftab[0]; in_sub = 1'b0; in_tag = sent[3:0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++; $display("FAIL b2b_in_ready cyc %0d got %b want %b", cyc, in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_tag !== rcvd[3:0] || out_res !== ftab[rcvd + 1]) begin
                    errors++; $display("FAIL b2b_result[%0d] got %h/%h want %h/%h", rcvd, out_tag, out_res, rcvd[3:0], ftab[rcvd + 1]);
                end
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (rcvd != 10) begin errors++; $display("FAIL b2b_count got %0d want 10", rcvd); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra got valid tag %h want none", out_tag); end
        end
    endtask

    task automatic test_reset_flight;
        logic [31:0] r; logic [3:0] f, t; int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = ftab[i]; in_b = ftab[0]; in_sub = 1'b0; in_tag = 4'(i + 10);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flight_pre_valid got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_valid_drop got %b want 0", out_valid); end
        checks++; if (out_res !== 32'h0 || out_tag !== 4'h0) begin errors++; $display("FAIL flight_clear got %h/%h want 00000000/0", out_res, out_tag); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h40000000, 32'h40000000, 1'b0, 4'h3, r, f, t, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL flight_latency got %0d want 4", lat); end
        checks++; if (t !== 4'h3) begin errors++; $display("FAIL flight_tag got %h want 3", t); end
        checks++; if (r !== 32'h40800000) begin errors++; $display("FAIL flight_res got %h want 40800000", r); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_rounding();
        test_range();
        test_specials();
        test_back_to_back();
        test_reset_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
